// File: rtl/tff.sv
// Bank of WIDTH independent toggle flip-flops with per-bit edge flags and a
// saturating count of clock edges at which at least one bit toggled.
module tff #(
    parameter int                 WIDTH       = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}},
    parameter int                 CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     t,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     qn,
    output logic [WIDTH-1:0]     rise,
    output logic [WIDTH-1:0]     fall,
    output logic [CNT_WIDTH-1:0] toggle_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [WIDTH-1:0]     q_q,    q_d;
    logic [WIDTH-1:0]     rise_q, rise_d;
    logic [WIDTH-1:0]     fall_q, fall_d;
    logic [CNT_WIDTH-1:0] cnt_q,  cnt_d;
    logic                 any_toggle;

    assign any_toggle = |t;

    always_comb begin
        q_d    = q_q;
        rise_d = '0;
        fall_d = '0;
        cnt_d  = cnt_q;
        if (rst) begin
            q_d   = RESET_VALUE;
            cnt_d = '0;
        end else begin
            q_d    = q_q ^ t;
            // Edge flags describe the transition just taken, so they use the old q.
            rise_d = t & ~q_q;
            fall_d = t & q_q;
            if (any_toggle && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        q_q    <= q_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
        cnt_q  <= cnt_d;
    end

    assign q          = q_q;
    assign qn         = ~q_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_tff.sv
// Bench for tff: a default single-bit instance, a 2-bit-counter instance for
// saturation, and a 4-bit instance with a non-zero reset value.
module tb_tff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // default instance
    logic       d_rst, d_t, d_q, d_qn, d_rise, d_fall;
    logic [7:0] d_cnt;
    // saturation instance
    logic       s_rst, s_t, s_q, s_qn, s_rise, s_fall;
    logic [1:0] s_cnt;
    // multi-bit instance
    logic       m_rst;
    logic [3:0] m_t, m_q, m_qn, m_rise, m_fall;
    logic [7:0] m_cnt;

    tff u_def (.clk(clk), .rst(d_rst), .t(d_t), .q(d_q), .qn(d_qn),
               .rise(d_rise), .fall(d_fall), .toggle_cnt(d_cnt));

    tff #(.WIDTH(1), .RESET_VALUE(1'b0), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(s_rst), .t(s_t), .q(s_q), .qn(s_qn),
        .rise(s_rise), .fall(s_fall), .toggle_cnt(s_cnt));

    tff #(.WIDTH(4), .RESET_VALUE(4'b1010), .CNT_WIDTH(8)) u_mb (
        .clk(clk), .rst(m_rst), .t(m_t), .q(m_q), .qn(m_qn),
        .rise(m_rise), .fall(m_fall), .toggle_cnt(m_cnt));

    // Reference state: plain integers, one set per instance.
    int dq, drise, dfall, dcnt;
    int sq, srise, sfall, scnt;
    int mq, mrise, mfall, mcnt;

    // Behavioural rule: every bit with t set flips; the flag records which way it went.
    task automatic ref_step(input int w, input int rv, input int cmax, input bit r,
                            input int tv, inout int q, inout int rise, inout int fall,
                            inout int cnt);
        int nq;
        if (r) begin
            q = rv; rise = 0; fall = 0; cnt = 0;
        end else begin
            nq = q; rise = 0; fall = 0;
            for (int i = 0; i < w; i++) begin
                if (((tv >> i) & 1) == 1) begin
                    if (((q >> i) & 1) == 0) begin
                        nq = nq + (1 << i); rise = rise + (1 << i);
                    end else begin
                        nq = nq - (1 << i); fall = fall + (1 << i);
                    end
                end
            end
            q = nq;
            if (tv != 0 && cnt < cmax) cnt = cnt + 1;
        end
    endtask

    task automatic tick(input bit dr, input logic dtv, input bit sr, input logic stv,
                        input bit mr, input logic [3:0] mtv);
        @(negedge clk);
        d_rst = dr; d_t = dtv; s_rst = sr; s_t = stv; m_rst = mr; m_t = mtv;
        @(posedge clk);
        ref_step(1, 0, 255, dr, int'(dtv), dq, drise, dfall, dcnt);
        ref_step(1, 0, 3, sr, int'(stv), sq, srise, sfall, scnt);
        ref_step(4, 10, 255, mr, int'(mtv), mq, mrise, mfall, mcnt);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 1, 0, 1, 4'h0);
        tick(1, 0, 1, 0, 1, 4'h0);
        checks++; if (d_q !== 1'b0) begin errors++; $display("FAIL reset_q got=%b exp=0", d_q); end
        checks++; if (d_qn !== 1'b1) begin errors++; $display("FAIL reset_qn got=%b exp=1", d_qn); end
        checks++; if (d_rise !== 1'b0 || d_fall !== 1'b0) begin errors++;
            $display("FAIL reset_flags got=%b%b exp=00", d_rise, d_fall); end
        checks++; if (d_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", d_cnt); end
        checks++; if (m_q !== 4'b1010 || m_qn !== 4'b0101) begin errors++;
            $display("FAIL reset_mb_q got=%b/%b exp=1010/0101", m_q, m_qn); end
    endtask

    task automatic test_hold();
        tick(0, 0, 1, 0, 1, 4'h0);
        checks++; if (d_q !== 1'b0 || d_cnt !== 8'd0) begin errors++;
            $display("FAIL hold got q=%b cnt=%0d exp q=0 cnt=0", d_q, d_cnt); end
    endtask

    task automatic test_toggle();
        logic       exp_q[4]    = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] exp_cnt[4]  = '{8'd1, 8'd2, 8'd3, 8'd4};
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 1, 0, 1, 4'h0);
            checks++;
            if (d_q !== exp_q[i] || d_qn !== ~exp_q[i] || d_rise !== exp_q[i] ||
                d_fall !== ~exp_q[i] || d_cnt !== exp_cnt[i]) begin
                errors++;
                $display("FAIL toggle_%0d got q=%b qn=%b r=%b f=%b cnt=%0d exp q=%b cnt=%0d",
                         i, d_q, d_qn, d_rise, d_fall, d_cnt, exp_q[i], exp_cnt[i]);
            end
        end
        tick(0, 0, 1, 0, 1, 4'h0);
        checks++; if (d_q !== 1'b0 || d_rise !== 1'b0 || d_fall !== 1'b0 || d_cnt !== 8'd4) begin
            errors++; $display("FAIL toggle_stop got q=%b r=%b f=%b cnt=%0d exp 0 0 0 4",
                               d_q, d_rise, d_fall, d_cnt); end
    endtask

    task automatic test_reset_priority();
        tick(0, 1, 1, 0, 1, 4'h0);
        checks++; if (d_q !== 1'b1) begin errors++; $display("FAIL prio_setup got=%b exp=1", d_q); end
        tick(1, 1, 1, 0, 1, 4'h0);
        checks++; if (d_q !== 1'b0 || d_rise !== 1'b0 || d_fall !== 1'b0 || d_cnt !== 8'd0) begin
            errors++; $display("FAIL prio got q=%b r=%b f=%b cnt=%0d exp 0 0 0 0",
                               d_q, d_rise, d_fall, d_cnt); end
    endtask

    task automatic test_back_to_back();
        tick(1, 1, 1, 0, 1, 4'h0);
        tick(0, 1, 1, 0, 1, 4'h0);
        checks++; if (d_q !== 1'b1 || d_rise !== 1'b1 || d_cnt !== 8'd1) begin errors++;
            $display("FAIL b2b_release got q=%b r=%b cnt=%0d exp 1 1 1", d_q, d_rise, d_cnt); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        tick(0, 0, 1, 0, 1, 4'h0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 1, 1, 4'h0);
            checks++; if (s_cnt !== exp_cnt[i]) begin errors++;
                $display("FAIL sat_%0d got=%0d exp=%0d", i, s_cnt, exp_cnt[i]); end
        end
    endtask

    task automatic test_multibit();
        tick(0, 0, 1, 0, 1, 4'h0);
        tick(0, 0, 1, 0, 0, 4'b0110);
        checks++; if (m_q !== 4'b1100 || m_rise !== 4'b0100 || m_fall !== 4'b0010 ||
                      m_qn !== 4'b0011 || m_cnt !== 8'd1) begin
            errors++; $display("FAIL multibit got q=%b r=%b f=%b qn=%b cnt=%0d exp 1100 0100 0010 0011 1",
                               m_q, m_rise, m_fall, m_qn, m_cnt); end
    endtask

    task automatic test_random();
        int bad;
        for (int i = 0; i < 300; i++) begin
            tick(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)));
            bad = 0;
            if (d_q !== 1'(dq) || d_qn !== ~1'(dq) || d_rise !== 1'(drise) ||
                d_fall !== 1'(dfall) || d_cnt !== 8'(dcnt)) bad = 1;
            if (s_q !== 1'(sq) || s_qn !== ~1'(sq) || s_rise !== 1'(srise) ||
                s_fall !== 1'(sfall) || s_cnt !== 2'(scnt)) bad = bad + 2;
            if (m_q !== 4'(mq) || m_qn !== ~4'(mq) || m_rise !== 4'(mrise) ||
                m_fall !== 4'(mfall) || m_cnt !== 8'(mcnt)) bad = bad + 4;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL random_%0d mask=%0d got d=%b/%b/%b/%0d s=%b/%b/%b/%0d m=%b/%b/%b/%0d exp d=%0d/%0d/%0d/%0d s=%0d/%0d/%0d/%0d m=%0d/%0d/%0d/%0d",
                         i, bad, d_q, d_rise, d_fall, d_cnt, s_q, s_rise, s_fall, s_cnt,
                         m_q, m_rise, m_fall, m_cnt, dq, drise, dfall, dcnt,
                         sq, srise, sfall, scnt, mq, mrise, mfall, mcnt);
            end
        end
    endtask

    initial begin
        d_rst = 1'b1; d_t = 1'b0; s_rst = 1'b1; s_t = 1'b0; m_rst = 1'b1; m_t = 4'h0;
        test_reset();
        test_hold();
        test_toggle();
        test_reset_priority();
        test_back_to_back();
        test_saturation();
        test_multibit();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
